// File: rtl/ssg_frame_pkg.sv
// ssg_frame_pkg: shared types and constants for the SSG frame builder and
// the pattern logic that consumes its frames.
//   state_e          builder FSM states
//   LAYER_1/LAYER_2  layer select encodings carried on in_layer
//   SSG_WEIGHT/WIDTH default segment word width / channels per layer
//   idx_w()          channel index width, never below 1 bit
package ssg_frame_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      EMIT = 2'd2
   } state_e;

   localparam logic LAYER_1 = 1'b0;
   localparam logic LAYER_2 = 1'b1;

   localparam int SSG_WEIGHT = 5;
   localparam int SSG_WIDTH  = 2;

   function automatic int idx_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/ssg_frame_if.sv
// ssg_frame_if: beat stream from the SSG link decoder into the frame builder.
//   in_valid/in_ready  handshake, beat moves when both are high
//   in_layer           target layer (LAYER_1 / LAYER_2)
//   in_idx             channel index
//   in_data            segment word
//   in_last            final beat of the frame
// master = decoder side, slave = builder side.
interface ssg_frame_if
   import ssg_frame_pkg::*;
#(
   parameter int WEIGHT = SSG_WEIGHT,
   parameter int X      = idx_w(SSG_WIDTH)
);
   logic              in_valid;
   logic              in_ready;
   logic              in_layer;
   logic [X-1:0]      in_idx;
   logic [WEIGHT-1:0] in_data;
   logic              in_last;

   modport master (output in_valid, in_layer, in_idx, in_data, in_last,
                   input  in_ready);
   modport slave  (input  in_valid, in_layer, in_idx, in_data, in_last,
                   output in_ready);
endinterface

// File: rtl/ssg_frame_shadow.sv
// ssg_frame_shadow: one layer's shadow array and written-mask.
//   clk, reset  clock, synchronous active-high reset
//   wr_en_i     write this layer (index already range-checked)
//   wr_idx_i    channel index
//   wr_data_i   segment word
//   clr_i       discard the shadow contents (frame emitted or aborted)
//   nxt_o       shadow contents including this cycle's write, so the parent
//               can capture a frame on the same edge as its last beat
//   dup_o       this write hits an entry already written in the frame
module ssg_frame_shadow
   import ssg_frame_pkg::*;
#(
   parameter int WEIGHT = SSG_WEIGHT,
   parameter int WIDTH  = SSG_WIDTH,
   parameter int X      = idx_w(WIDTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en_i,
   input  logic [X-1:0]      wr_idx_i,
   input  logic [WEIGHT-1:0] wr_data_i,
   input  logic              clr_i,
   output logic [WEIGHT-1:0] nxt_o [WIDTH-1:0],
   output logic              dup_o
);

   logic [WEIGHT-1:0] shd_q [WIDTH-1:0];
   logic [WEIGHT-1:0] shd_d [WIDTH-1:0];
   logic [WIDTH-1:0]  mask_q, mask_d;

   always_comb begin
      shd_d  = shd_q;
      mask_d = mask_q;
      dup_o  = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (wr_en_i && (wr_idx_i == X'(i))) begin
            shd_d[i]  = wr_data_i;
            mask_d[i] = 1'b1;
            dup_o     = mask_q[i];
         end
      end
   end

   assign nxt_o = shd_d;

   always_ff @(posedge clk) begin
      if (reset || clr_i) begin
         for (int i = 0; i < WIDTH; i++) shd_q[i] <= '0;
         mask_q <= '0;
      end else begin
         shd_q  <= shd_d;
         mask_q <= mask_d;
      end
   end

endmodule

// File: rtl/ssg_frame_builder.sv
// ssg_frame_builder: assembles two layer frames from a beat stream of
// per-channel segment words and presents them together with a one-cycle
// out_valid strobe.
//   clk, reset   clock, synchronous active-high reset
//   bus          ssg_frame_if.slave beat stream (in_ready low only in EMIT)
//   out_valid    one-cycle strobe, cycle after the in_last beat
//   frame_1/2    layer frames, held until the next strobe
//   err_idx      sticky, beat with in_idx >= WIDTH dropped
//   err_dup      sticky, same layer/index written twice in one frame
//   err_timeout  sticky, open frame aborted after TIMEOUT idle cycles
// Optional: define SSG_FRAME_TIMEOUT_EN to build the FILL idle timeout
// (adds parameter TIMEOUT); otherwise err_timeout is tied 0.
module ssg_frame_builder
   import ssg_frame_pkg::*;
#(
   parameter int WEIGHT  = SSG_WEIGHT,
   parameter int WIDTH   = SSG_WIDTH,
   parameter int X       = idx_w(WIDTH)
`ifdef SSG_FRAME_TIMEOUT_EN
   , parameter int TIMEOUT = 64
`endif
) (
   input  logic              clk,
   input  logic              reset,
   ssg_frame_if.slave        bus,
   output logic              out_valid,
   output logic [WEIGHT-1:0] frame_1 [WIDTH-1:0],
   output logic [WEIGHT-1:0] frame_2 [WIDTH-1:0],
   output logic              err_idx,
   output logic              err_dup,
   output logic              err_timeout
);

   state_e state_q, state_d;

   logic              acc, idx_ok, emit_go, clr, tmo_fire;
   logic [1:0]        dup;
   logic [WEIGHT-1:0] nxt [2][WIDTH-1:0];

   assign bus.in_ready = (state_q != EMIT);
   assign acc          = bus.in_valid && bus.in_ready;
   assign idx_ok       = int'(bus.in_idx) < WIDTH;
   assign emit_go      = acc && bus.in_last;
   // Shadow is dropped once its contents have been captured into the
   // frames, or when an open frame is abandoned.
   assign clr          = (state_q == EMIT) || tmo_fire;
   assign out_valid    = (state_q == EMIT);

   for (genvar g = 0; g < 2; g++) begin : g_layer
      ssg_frame_shadow #(
         .WEIGHT (WEIGHT),
         .WIDTH  (WIDTH),
         .X      (X)
      ) u_shadow (
         .clk       (clk),
         .reset     (reset),
         .wr_en_i   (acc && idx_ok && (bus.in_layer == 1'(g))),
         .wr_idx_i  (bus.in_idx),
         .wr_data_i (bus.in_data),
         .clr_i     (clr),
         .nxt_o     (nxt[g]),
         .dup_o     (dup[g])
      );
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (acc) state_d = bus.in_last ? EMIT : FILL;
         FILL: begin
            if (emit_go)       state_d = EMIT;
            else if (tmo_fire) state_d = IDLE;
         end
         EMIT:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         err_idx <= 1'b0;
         err_dup <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            frame_1[i] <= '0;
            frame_2[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (acc && !idx_ok) err_idx <= 1'b1;
         if (|dup)           err_dup <= 1'b1;
         // Capture on the last beat's edge so frames are valid together
         // with out_valid.
         if (emit_go) begin
            frame_1 <= nxt[LAYER_1];
            frame_2 <= nxt[LAYER_2];
         end
      end
   end

`ifdef SSG_FRAME_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] tcnt_q, tcnt_d;
   logic          err_tmo_q;

   // Counts idle FILL cycles; fires on the TIMEOUT-th one unless a beat
   // lands in that same cycle.
   always_comb begin
      tcnt_d   = tcnt_q;
      tmo_fire = 1'b0;
      if ((state_q != FILL) || acc) begin
         tcnt_d = '0;
      end else if (tcnt_q == CW'(TIMEOUT - 1)) begin
         tmo_fire = 1'b1;
         tcnt_d   = '0;
      end else begin
         tcnt_d = tcnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt_q    <= '0;
         err_tmo_q <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         if (tmo_fire) err_tmo_q <= 1'b1;
      end
   end

   assign err_timeout = err_tmo_q;
`else
   assign tmo_fire    = 1'b0;
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ssg_frame_builder.sv
// tb_ssg_frame_builder: directed test of ssg_frame_builder.
// dut_a: WIDTH=2 (TIMEOUT=8 when SSG_FRAME_TIMEOUT_EN is defined).
// dut_b: WIDTH=3, X=2, used for the out-of-range index case.
module tb_ssg_frame_builder;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ssg_frame_if #(.WEIGHT(5), .X(1)) ifa ();
   ssg_frame_if #(.WEIGHT(5), .X(2)) ifb ();

   logic       ov_a, ov_b;
   logic [4:0] f1a [1:0], f2a [1:0];
   logic [4:0] f1b [2:0], f2b [2:0];
   logic       eia, eda, eta, eib, edb, etb;

   ssg_frame_builder #(
      .WEIGHT (5),
      .WIDTH  (2),
      .X      (1)
`ifdef SSG_FRAME_TIMEOUT_EN
      , .TIMEOUT (8)
`endif
   ) dut_a (
      .clk (clk), .reset (reset), .bus (ifa.slave),
      .out_valid (ov_a), .frame_1 (f1a), .frame_2 (f2a),
      .err_idx (eia), .err_dup (eda), .err_timeout (eta)
   );

   ssg_frame_builder #(
      .WEIGHT (5),
      .WIDTH  (3),
      .X      (2)
   ) dut_b (
      .clk (clk), .reset (reset), .bus (ifb.slave),
      .out_valid (ov_b), .frame_1 (f1b), .frame_2 (f2b),
      .err_idx (eib), .err_dup (edb), .err_timeout (etb)
   );

   int checks = 0;
   int failures = 0;
   int ov_cnt = 0;
   int snap;

   always @(posedge clk) if (ov_a === 1'b1) ov_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      tick(n);
      reset = 1'b0;
   endtask

   task automatic send_a(input logic l, input logic i, input logic [4:0] d, input logic last);
      ifa.in_valid = 1'b1; ifa.in_layer = l; ifa.in_idx = i;
      ifa.in_data = d; ifa.in_last = last;
      tick(1);
      ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
   endtask

   task automatic send_b(input logic l, input logic [1:0] i, input logic [4:0] d, input logic last);
      ifb.in_valid = 1'b1; ifb.in_layer = l; ifb.in_idx = i;
      ifb.in_data = d; ifb.in_last = last;
      tick(1);
      ifb.in_valid = 1'b0; ifb.in_last = 1'b0;
   endtask

   initial begin
      ifa.in_valid = 1'b0; ifa.in_layer = 1'b0; ifa.in_idx = '0;
      ifa.in_data = '0; ifa.in_last = 1'b0;
      ifb.in_valid = 1'b0; ifb.in_layer = 1'b0; ifb.in_idx = '0;
      ifb.in_data = '0; ifb.in_last = 1'b0;
      @(posedge clk); #1;
      do_reset(2);

      // reset state
      chk("rst_ov", ov_a, 0);
      chk("rst_rdy", ifa.in_ready, 1);
      chk("rst_f1_0", f1a[0], 0);
      chk("rst_f2_1", f2a[1], 0);
      chk("rst_errs", {eia, eda, eta}, 0);

      // basic frame
      send_a(0, 0, 5'h03, 0);
      send_a(0, 1, 5'h1F, 0);
      send_a(1, 0, 5'h0A, 0);
      chk("fill_ov", ov_a, 0);
      chk("fill_rdy", ifa.in_ready, 1);
      send_a(1, 1, 5'h11, 1);
      chk("basic_ov", ov_a, 1);
      chk("basic_rdy", ifa.in_ready, 0);
      chk("basic_f1_0", f1a[0], 5'h03);
      chk("basic_f1_1", f1a[1], 5'h1F);
      chk("basic_f2_0", f2a[0], 5'h0A);
      chk("basic_f2_1", f2a[1], 5'h11);
      tick(1);
      chk("basic_ov_drop", ov_a, 0);
      chk("basic_rdy_back", ifa.in_ready, 1);
      chk("basic_hold", f1a[1], 5'h1F);

      // sparse single-beat frame
      send_a(1, 1, 5'h07, 1);
      chk("sparse_ov", ov_a, 1);
      chk("sparse_f1_0", f1a[0], 0);
      chk("sparse_f1_1", f1a[1], 0);
      chk("sparse_f2_0", f2a[0], 0);
      chk("sparse_f2_1", f2a[1], 5'h07);
      chk("sparse_nodup", eda, 0);
      tick(1);

      // duplicate write
      send_a(0, 0, 5'h01, 0);
      send_a(0, 0, 5'h02, 1);
      chk("dup_f1_0", f1a[0], 5'h02);
      chk("dup_err", eda, 1);
      tick(1);
      send_a(1, 0, 5'h15, 1);
      chk("dup_next_f2_0", f2a[0], 5'h15);
      chk("dup_next_f1_0", f1a[0], 0);
      chk("dup_sticky", eda, 1);
      chk("dup_noidx", eia, 0);
      tick(1);

      // out-of-range index on WIDTH=3
      send_b(0, 2'd3, 5'h1F, 1);
      chk("bidx_ov", ov_b, 1);
      chk("bidx_err", eib, 1);
      chk("bidx_f1", {f1b[2], f1b[1], f1b[0]}, 0);
      chk("bidx_f2", {f2b[2], f2b[1], f2b[0]}, 0);
      tick(1);
      send_b(1, 2'd2, 5'h0C, 1);
      chk("bidx_next_f2_2", f2b[2], 5'h0C);
      chk("bidx_sticky", eib, 1);

      // reset mid-frame
      snap = ov_cnt;
      send_a(0, 0, 5'h1A, 0);
      send_a(1, 1, 5'h1B, 0);
      do_reset(1);
      chk("rmid_errclr", eda, 0);
      send_a(0, 0, 5'h04, 1);
      chk("rmid_ov", ov_a, 1);
      chk("rmid_f1_0", f1a[0], 5'h04);
      chk("rmid_f2_1", f2a[1], 0);
      tick(2);
      chk("rmid_pulses", ov_cnt - snap, 1);

`ifdef SSG_FRAME_TIMEOUT_EN
      // timeout fires after 8 idle cycles
      snap = ov_cnt;
      send_a(0, 0, 5'h05, 0);
      tick(7);
      chk("tmo_early", eta, 0);
      tick(1);
      chk("tmo_err", eta, 1);
      chk("tmo_rdy", ifa.in_ready, 1);
      tick(2);
      chk("tmo_no_ov", ov_cnt - snap, 0);

      // beat on idle cycle 8 suppresses the timeout
      do_reset(1);
      send_a(0, 0, 5'h05, 0);
      tick(7);
      send_a(0, 1, 5'h06, 0);
      tick(3);
      chk("tmo_saved", eta, 0);
      send_a(1, 0, 5'h07, 1);
      chk("tmo_saved_ov", ov_a, 1);
      chk("tmo_saved_f1", {f1a[1], f1a[0]}, {5'h06, 5'h05});
      chk("tmo_saved_f2_0", f2a[0], 5'h07);
`else
      tick(80);
      chk("tmo_tied", eta, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
